// File: rtl/operand_entry_pkg.sv
// Shared types and constants for the operand entry front end.
// Step encoding doubles as the prompt code driven to the display layer.
package operand_entry_pkg;

  typedef enum logic [1:0] {
    GET_A   = 2'd0,
    GET_B   = 2'd1,
    GET_CIN = 2'd2,
    DONE    = 2'd3
  } entry_step_t;

  localparam int unsigned CLK_HZ = 50_000_000;
  localparam int unsigned DEBOUNCE_MS = 10;
  localparam int unsigned DEBOUNCE_DEFAULT =
    CLK_HZ / 1000 * DEBOUNCE_MS;

endpackage

// File: rtl/operand_entry_key_debounce.sv
// Synchronizes and debounces one active-low push-button.
// Emits a one-cycle press pulse on the accepted falling edge.
module key_debounce
  import operand_entry_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX =
    CW'(DEBOUNCE_CYCLES - 1);

  logic          meta_q;
  logic          sync_q;
  logic          level_q;
  logic          press_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= key_n;
      sync_q <= meta_q;
    end
  end

  // Any sample matching the held level restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      press_q <= 1'b0;
      if (sync_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        level_q <= sync_q;
        press_q <= ~sync_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/operand_entry.sv
// Operand A/B/Cin entry sequencer for the adder datapath.
// Switch inputs are synchronized here; buttons in key_debounce.
module operand_entry
  import operand_entry_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic             cin_sw,
  input  logic             key_enter_n,
  input  logic             key_clear_n,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             cin,
  output logic             valid,
  output logic [1:0]       step
);

  logic [WIDTH-1:0] sw_meta_q;
  logic [WIDTH-1:0] sw_sync_q;
  logic             cin_meta_q;
  logic             cin_sync_q;

  logic             ent_press;
  logic             clr_press;

  entry_step_t      state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             cin_q;
  logic             valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      cin_meta_q <= 1'b0;
      cin_sync_q <= 1'b0;
    end else begin
      sw_meta_q  <= sw;
      sw_sync_q  <= sw_meta_q;
      cin_meta_q <= cin_sw;
      cin_sync_q <= cin_meta_q;
    end
  end

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_enter (
    .clk  (clk),
    .rst  (rst),
    .key_n(key_enter_n),
    .level(),
    .press(ent_press)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_clear (
    .clk  (clk),
    .rst  (rst),
    .key_n(key_clear_n),
    .level(),
    .press(clr_press)
  );

  // Clear outranks a coincident enter pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= GET_A;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      valid_q <= 1'b0;
    end else if (clr_press) begin
      state_q <= GET_A;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      valid_q <= 1'b0;
    end else if (ent_press) begin
      unique case (state_q)
        GET_A: begin
          a_q     <= sw_sync_q;
          state_q <= GET_B;
        end
        GET_B: begin
          b_q     <= sw_sync_q;
          state_q <= GET_CIN;
        end
        GET_CIN: begin
          cin_q   <= cin_sync_q;
          valid_q <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          valid_q <= 1'b0;
          state_q <= GET_A;
        end
        default: state_q <= GET_A;
      endcase
    end
  end

  assign a     = a_q;
  assign b     = b_q;
  assign cin   = cin_q;
  assign valid = valid_q;
  assign step  = state_q;

endmodule

// File: tb/tb_operand_entry.sv
// Directed bench for operand_entry with a short debounce window.
// Inputs change 1 time unit after a rising edge; outputs sampled there.
module tb_operand_entry;

  localparam int W = 4;
  localparam int DB = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] sw;
  logic         cin_sw;
  logic         key_enter_n;
  logic         key_clear_n;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         valid;
  logic [1:0]   step;

  int n_cmp;
  int n_err;
  int n_press;
  int p0;

  operand_entry #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sw         (sw),
    .cin_sw     (cin_sw),
    .key_enter_n(key_enter_n),
    .key_clear_n(key_clear_n),
    .a          (a),
    .b          (b),
    .cin        (cin),
    .valid      (valid),
    .step       (step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (dut.u_enter.press === 1'b1) n_press++;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag,
                         input logic [1:0] e_step,
                         input logic [3:0] e_a,
                         input logic [3:0] e_b,
                         input logic e_cin,
                         input logic e_valid);
    chk({tag, ".step"}, {6'd0, step}, {6'd0, e_step});
    chk({tag, ".a"}, {4'd0, a}, {4'd0, e_a});
    chk({tag, ".b"}, {4'd0, b}, {4'd0, e_b});
    chk({tag, ".cin"}, {7'd0, cin}, {7'd0, e_cin});
    chk({tag, ".valid"}, {7'd0, valid}, {7'd0, e_valid});
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    n_press = 0;
    rst = 1'b1;
    sw = '0;
    cin_sw = 1'b0;
    key_enter_n = 1'b1;
    key_clear_n = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
    chk_all("reset", 2'd0, 4'h0, 4'h0, 1'b0, 1'b0);

    // Full entry: each update lands 7 edges after the raw edge
    sw = 4'hA;
    key_enter_n = 1'b0;
    tick(6);
    chk("lat_a_early.step", {6'd0, step}, 8'd0);
    tick(1);
    chk_all("enter_a", 2'd1, 4'hA, 4'h0, 1'b0, 1'b0);
    key_enter_n = 1'b1;
    tick(10);

    sw = 4'h7;
    key_enter_n = 1'b0;
    tick(6);
    chk("lat_b_early.b", {4'd0, b}, 8'h00);
    tick(1);
    chk_all("enter_b", 2'd2, 4'hA, 4'h7, 1'b0, 1'b0);
    key_enter_n = 1'b1;
    tick(10);

    cin_sw = 1'b1;
    key_enter_n = 1'b0;
    tick(7);
    chk_all("enter_cin", 2'd3, 4'hA, 4'h7, 1'b1, 1'b1);
    key_enter_n = 1'b1;
    tick(10);

    // Wrap from DONE keeps old operands
    key_enter_n = 1'b0;
    tick(7);
    chk_all("wrap", 2'd0, 4'hA, 4'h7, 1'b1, 1'b0);
    key_enter_n = 1'b1;
    tick(10);
    sw = 4'h3;
    key_enter_n = 1'b0;
    tick(7);
    chk_all("wrap_a3", 2'd1, 4'h3, 4'h7, 1'b1, 1'b0);
    key_enter_n = 1'b1;
    tick(10);

    // Clear and enter accepted on the same edge in GET_B
    key_enter_n = 1'b0;
    key_clear_n = 1'b0;
    tick(7);
    chk_all("clear_prio", 2'd0, 4'h0, 4'h0, 1'b0, 1'b0);
    key_enter_n = 1'b1;
    key_clear_n = 1'b1;
    tick(10);

    // Hold: one advance only
    sw = 4'h9;
    p0 = n_press;
    key_enter_n = 1'b0;
    tick(100);
    chk("hold.step", {6'd0, step}, 8'd1);
    chk("hold.a", {4'd0, a}, 8'h09);
    chk("hold.pulses", 8'(n_press - p0), 8'd1);
    key_enter_n = 1'b1;
    tick(10);
    key_clear_n = 1'b0;
    tick(10);
    key_clear_n = 1'b1;
    tick(10);
    chk("reclear.step", {6'd0, step}, 8'd0);

    // Bounce: glitches of 2 cycles never qualify
    sw = 4'h5;
    p0 = n_press;
    for (int i = 0; i < 5; i++) begin
      key_enter_n = 1'b0;
      tick(2);
      key_enter_n = 1'b1;
      tick(2);
    end
    chk("bounce.none", 8'(n_press - p0), 8'd0);
    key_enter_n = 1'b0;
    tick(5);
    chk("bounce.pre", {7'd0, dut.u_enter.press}, 8'd0);
    tick(1);
    chk("bounce.pulse", {7'd0, dut.u_enter.press}, 8'd1);
    tick(1);
    chk("bounce.step", {6'd0, step}, 8'd1);
    chk("bounce.a", {4'd0, a}, 8'h05);
    tick(20);
    chk("bounce.once", 8'(n_press - p0), 8'd1);
    key_enter_n = 1'b1;
    tick(10);

    // Switch change during debounce is tracked
    sw = 4'h1;
    key_enter_n = 1'b0;
    tick(3);
    sw = 4'hE;
    tick(4);
    chk("track.b", {4'd0, b}, 8'h0E);
    chk("track.step", {6'd0, step}, 8'd2);
    key_enter_n = 1'b1;
    tick(10);

    // Async reset between edges, then key held across release
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 2'd0, 4'h0, 4'h0, 1'b0, 1'b0);
    key_enter_n = 1'b0;
    sw = 4'h6;
    tick(2);
    rst = 1'b0;
    tick(6);
    chk("held_rst.pre", {6'd0, step}, 8'd0);
    tick(1);
    chk("held_rst.step", {6'd0, step}, 8'd1);
    chk("held_rst.a", {4'd0, a}, 8'h06);
    key_enter_n = 1'b1;
    tick(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
